// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the unified memory between the core and the EXT loader/debug port.
// Round-robin tie-break, one outstanding read, and read data is routed back to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  // state   | meaning
  // IDLE    | no read outstanding
  // RD_WAIT | one read outstanding, lat_cnt cycles left (return cycle at lat_cnt==1)

  localparam logic CORE = 1'b0;
  localparam logic EXT  = 1'b1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t     state, state_n;
  logic [2:0] lat_cnt, lat_n;
  logic       rd_owner, owner_n;
  logic       last_win, last_win_n;
  logic       ret, grant, win, win_we;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= 3'd0;
      rd_owner <= CORE;
      last_win <= EXT;
    end else begin
      state    <= state_n;
      lat_cnt  <= lat_n;
      rd_owner <= owner_n;
      last_win <= last_win_n;
    end
  end

  always_comb begin
    ret   = (state == RD_WAIT) && (lat_cnt == 3'd1);
    // The return cycle frees the port, so a new access can be granted back-to-back.
    grant = !rst && ((state == IDLE) || ret) && (core_req || ext_req);
    if (core_req && ext_req) win = ~last_win;
    else                     win = ext_req ? EXT : CORE;
    win_we = (win == EXT) ? ext_we : core_we;

    core_gnt  = grant && (win == CORE);
    ext_gnt   = grant && (win == EXT);
    mem_en    = grant;
    mem_we    = grant && win_we;
    mem_addr  = ext_gnt ? ext_addr  : core_addr;
    mem_wdata = ext_gnt ? ext_wdata : core_wdata;

    core_rvalid = !rst && ret && (rd_owner == CORE);
    ext_rvalid  = !rst && ret && (rd_owner == EXT);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    ext_rdata   = ext_rvalid  ? mem_rdata : '0;
    core_stall  = !rst && ((core_req && !core_gnt) ||
                           ((state == RD_WAIT) && (rd_owner == CORE) && !core_rvalid));

    state_n    = state;
    lat_n      = lat_cnt;
    owner_n    = rd_owner;
    last_win_n = last_win;
    if (state == RD_WAIT) begin
      if (ret) begin
        state_n = IDLE;
        lat_n   = 3'd0;
      end else begin
        lat_n = lat_cnt - 3'd1;
      end
    end
    if (grant) begin
      last_win_n = win;
      if (!win_we) begin
        state_n = RD_WAIT;
        lat_n   = 3'(MEM_LAT);
        owner_n = win;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 1, 2 and 3 share one stimulus set.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, ext_req, ext_we;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata, mem_rdata;

  logic        core_gnt_a [3];
  logic        core_rvalid_a [3];
  logic [31:0] core_rdata_a [3];
  logic        core_stall_a [3];
  logic        ext_gnt_a [3];
  logic        ext_rvalid_a [3];
  logic [31:0] ext_rdata_a [3];
  logic        mem_en_a [3];
  logic        mem_we_a [3];
  logic [31:0] mem_addr_a [3];
  logic [31:0] mem_wdata_a [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt_a[g]), .core_rvalid(core_rvalid_a[g]), .core_rdata(core_rdata_a[g]),
      .core_stall(core_stall_a[g]),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt_a[g]), .ext_rvalid(ext_rvalid_a[g]), .ext_rdata(ext_rdata_a[g]),
      .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]), .mem_rdata(mem_rdata)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    idle_inputs();
    // 1: reset with both requesting
    core_req = 1; ext_req = 1; core_addr = 32'h4; ext_addr = 32'h8;
    cyc();
    cyc();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_core_gnt", 32'(core_gnt_a[i]), 0);
      chk("rst_ext_gnt", 32'(ext_gnt_a[i]), 0);
      chk("rst_mem_en", 32'(mem_en_a[i]), 0);
      chk("rst_stall", 32'(core_stall_a[i]), 0);
      chk("rst_rvalid", 32'(core_rvalid_a[i] | ext_rvalid_a[i]), 0);
    end
    rst = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("first_core_gnt", 32'(core_gnt_a[i]), 1);
      chk("first_ext_gnt", 32'(ext_gnt_a[i]), 0);
      chk("first_addr", mem_addr_a[i], 32'h4);
    end

    // 2: core read, MEM_LAT=2 (instance 1)
    do_reset();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    #1;
    chk("rd2_gnt_T", 32'(core_gnt_a[1]), 1);
    chk("rd2_mem_en_T", 32'(mem_en_a[1]), 1);
    chk("rd2_mem_we_T", 32'(mem_we_a[1]), 0);
    chk("rd2_addr_T", mem_addr_a[1], 32'h10);
    chk("rd2_stall_T", 32'(core_stall_a[1]), 0);
    cyc();
    core_req = 0;
    #1;
    chk("rd2_stall_T1", 32'(core_stall_a[1]), 1);
    chk("rd2_rvalid_T1", 32'(core_rvalid_a[1]), 0);
    cyc();
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd2_rvalid_T2", 32'(core_rvalid_a[1]), 1);
    chk("rd2_rdata_T2", core_rdata_a[1], 32'hDEADBEEF);
    chk("rd2_stall_T2", 32'(core_stall_a[1]), 0);
    chk("rd2_ext_rvalid_T2", 32'(ext_rvalid_a[1]), 0);
    chk("rd2_ext_rdata_T2", ext_rdata_a[1], 0);
    cyc();
    mem_rdata = 0;
    #1;
    chk("rd2_rvalid_T3", 32'(core_rvalid_a[1]), 0);
    chk("rd2_stall_T3", 32'(core_stall_a[1]), 0);

    // 3: contention, MEM_LAT=1 (instance 0)
    do_reset();
    core_req = 1; ext_req = 1; core_addr = 32'h100; ext_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      mem_rdata = 32'h1000 + 32'(k);
      #1;
      chk("rr_core_gnt", 32'(core_gnt_a[0]), (k % 2 == 0) ? 1 : 0);
      chk("rr_ext_gnt", 32'(ext_gnt_a[0]), (k % 2 == 1) ? 1 : 0);
      chk("rr_addr", mem_addr_a[0], (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_core_rvalid", 32'(core_rvalid_a[0]), (k > 0 && k % 2 == 1) ? 1 : 0);
      chk("rr_ext_rvalid", 32'(ext_rvalid_a[0]), (k > 0 && k % 2 == 0) ? 1 : 0);
      chk("rr_core_rdata", core_rdata_a[0], (k % 2 == 1) ? 32'h1000 + 32'(k) : 0);
      chk("rr_ext_rdata", ext_rdata_a[0], (k > 0 && k % 2 == 0) ? 32'h1000 + 32'(k) : 0);
      cyc();
    end

    // 4: EXT writes while core idle, back-to-back (instance 0)
    do_reset();
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'h1234;
    #1;
    chk("wr_ext_gnt0", 32'(ext_gnt_a[0]), 1);
    chk("wr_mem_en0", 32'(mem_en_a[0]), 1);
    chk("wr_mem_we0", 32'(mem_we_a[0]), 1);
    chk("wr_addr0", mem_addr_a[0], 32'h40);
    chk("wr_wdata0", mem_wdata_a[0], 32'h1234);
    chk("wr_stall0", 32'(core_stall_a[0]), 0);
    cyc();
    ext_addr = 32'h44; ext_wdata = 32'h5678;
    #1;
    chk("wr_ext_gnt1", 32'(ext_gnt_a[0]), 1);
    chk("wr_mem_we1", 32'(mem_we_a[0]), 1);
    chk("wr_addr1", mem_addr_a[0], 32'h44);
    chk("wr_wdata1", mem_wdata_a[0], 32'h5678);
    cyc();
    ext_req = 0; ext_we = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wr_no_rvalid_l1", 32'(ext_rvalid_a[0] | core_rvalid_a[0]), 0);
      chk("wr_no_rvalid_l3", 32'(ext_rvalid_a[2] | core_rvalid_a[2]), 0);
      chk("wr_mem_en_idle", 32'(mem_en_a[0]), 0);
      cyc();
    end

    // 5: overlap, MEM_LAT=3 (instance 2)
    do_reset();
    core_req = 1; core_addr = 32'h80; ext_req = 1; ext_addr = 32'hC0;
    #1;
    chk("ov_core_gnt_T", 32'(core_gnt_a[2]), 1);
    chk("ov_ext_gnt_T", 32'(ext_gnt_a[2]), 0);
    cyc();
    core_req = 0;
    #1;
    chk("ov_ext_gnt_T1", 32'(ext_gnt_a[2]), 0);
    chk("ov_stall_T1", 32'(core_stall_a[2]), 1);
    cyc();
    #1;
    chk("ov_ext_gnt_T2", 32'(ext_gnt_a[2]), 0);
    chk("ov_mem_en_T2", 32'(mem_en_a[2]), 0);
    cyc();
    mem_rdata = 32'hA5A5;
    #1;
    chk("ov_core_rvalid_T3", 32'(core_rvalid_a[2]), 1);
    chk("ov_core_rdata_T3", core_rdata_a[2], 32'hA5A5);
    chk("ov_ext_gnt_T3", 32'(ext_gnt_a[2]), 1);
    chk("ov_addr_T3", mem_addr_a[2], 32'hC0);
    chk("ov_ext_rvalid_T3", 32'(ext_rvalid_a[2]), 0);
    cyc();
    ext_req = 0; mem_rdata = 0;
    #1;
    chk("ov_stall_T4", 32'(core_stall_a[2]), 0);
    chk("ov_core_rvalid_T4", 32'(core_rvalid_a[2]), 0);
    cyc();
    cyc();
    mem_rdata = 32'h5A5A;
    #1;
    chk("ov_ext_rvalid_T6", 32'(ext_rvalid_a[2]), 1);
    chk("ov_ext_rdata_T6", ext_rdata_a[2], 32'h5A5A);
    chk("ov_core_rvalid_T6", 32'(core_rvalid_a[2]), 0);
    chk("ov_core_rdata_T6", core_rdata_a[2], 0);

    // 6: reset mid-read, MEM_LAT=3 (instance 2)
    do_reset();
    core_req = 1; core_addr = 32'h10;
    #1;
    chk("mr_core_gnt_T", 32'(core_gnt_a[2]), 1);
    cyc();
    core_req = 0; rst = 1;
    #1;
    chk("mr_stall_rst", 32'(core_stall_a[2]), 0);
    chk("mr_mem_en_rst", 32'(mem_en_a[2]), 0);
    cyc();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      mem_rdata = 32'hBAD0 + 32'(k);
      #1;
      chk("mr_core_rvalid", 32'(core_rvalid_a[2]), 0);
      chk("mr_core_rdata", core_rdata_a[2], 0);
      chk("mr_stall", 32'(core_stall_a[2]), 0);
      cyc();
    end
    core_req = 1; ext_req = 1; core_addr = 32'h20; ext_addr = 32'h30;
    #1;
    chk("mr_post_core_gnt", 32'(core_gnt_a[2]), 1);
    chk("mr_post_ext_gnt", 32'(ext_gnt_a[2]), 0);
    chk("mr_post_addr", mem_addr_a[2], 32'h20);
    cyc();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
